// File: rtl/hex_display_ctrl_if.sv
// Host-side bus of the hex display controller: load/ack handshake,
// display controls and the committed value read-back.
interface hex_display_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int DATA_W = 4 * NUM_DIGITS;

  logic                  load;
  logic [DATA_W-1:0]     data_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  mode;
  logic                  blank_lz;
  logic                  load_ack;
  logic [DATA_W-1:0]     shown_value;

  modport master (
    output load, data_in, dp_in, mode, blank_lz,
    input  load_ack, shown_value
  );

  modport slave (
    input  load, data_in, dp_in, mode, blank_lz,
    output load_ack, shown_value
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display driver: holds a committed display value, offers
// a load/ack handshake, drives all digits statically and one digit per
// scan slot, with frame-aligned (tear-free) updates in scan mode,
// leading-zero blanking and per-digit decimal points.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  hex_display_ctrl_if.slave       bus,
  output logic [7*NUM_DIGITS-1:0] segs_static,
  output logic [NUM_DIGITS-1:0]   dp_static,
  output logic [6:0]              scan_seg,
  output logic                    scan_dp,
  output logic [NUM_DIGITS-1:0]   scan_an
);
  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  // Internal segment patterns are active-low; flip everything for active-high boards.
  localparam logic INV = (ACTIVE_LOW == 0);

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [DATA_W-1:0]     shown_q, shown_d;
  logic [NUM_DIGITS-1:0] shown_dp_q, shown_dp_d;
  logic [DATA_W-1:0]     pend_q, pend_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  load_ack_q, load_ack_d;

  logic                  frame_end;
  logic                  commit;
  logic                  nz_seen;
  logic                  blank_k;
  logic [6:0]            seg_al [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_onehot;

  // Next-state: pending capture, commit (immediate in static, frame end in scan), scan counters.
  always_comb begin
    frame_end    = (presc_q == PRE_MAX) && (idx_q == IDX_MAX);
    commit       = pend_valid_q && (!bus.mode || frame_end);
    shown_d      = shown_q;
    shown_dp_d   = shown_dp_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    presc_d      = presc_q;
    idx_d        = idx_q;
    load_ack_d   = commit;
    if (commit) begin
      shown_d      = pend_q;
      shown_dp_d   = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    // A load on the commit edge refills pending for the next commit.
    if (bus.load) begin
      pend_d       = bus.data_in;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end
    if (presc_q == PRE_MAX) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Control and committed display state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shown_q      <= '0;
      shown_dp_q   <= '0;
      pend_valid_q <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
      load_ack_q   <= 1'b0;
    end else begin
      shown_q      <= shown_d;
      shown_dp_q   <= shown_dp_d;
      pend_valid_q <= pend_valid_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      load_ack_q   <= load_ack_d;
    end
  end

  // Pending data is only meaningful while pend_valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_q    <= pend_d;
    pend_dp_q <= pend_dp_d;
  end

  // Per-digit patterns with leading-zero blanking, scanning from the top digit down.
  always_comb begin
    nz_seen = 1'b0;
    blank_k = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz_seen   = nz_seen | (shown_q[4*k +: 4] != 4'd0);
      blank_k   = bus.blank_lz && (k > 0) && !nz_seen;
      seg_al[k] = blank_k ? 7'b1111111 : hex_to_seg(shown_q[4*k +: 4]);
    end
  end

  // Pin drive: static digits plus the digit selected by the scan index.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      segs_static[7*k +: 7] = seg_al[k] ^ {7{INV}};
    end
    dp_static = ~shown_dp_q ^ {NUM_DIGITS{INV}};
    an_onehot = NUM_DIGITS'(1) << idx_q;
    scan_an   = ~an_onehot ^ {NUM_DIGITS{INV}};
    scan_seg  = seg_al[idx_q] ^ {7{INV}};
    scan_dp   = ~shown_dp_q[idx_q] ^ INV;
  end

  assign bus.load_ack    = load_ack_q;
  assign bus.shown_value = shown_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: NUM_DIGITS=4, SCAN_DIV=4, active-low pins.
module tb_hex_display_ctrl;
  localparam int ND = 4;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [27:0] segs_static;
  logic [3:0]  dp_static;
  logic [6:0]  scan_seg;
  logic        scan_dp;
  logic [3:0]  scan_an;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int ackcnt;
  int bad;

  localparam logic [6:0] BL = 7'b1111111;

  hex_display_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  hex_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .segs_static(segs_static), .dp_static(dp_static),
    .scan_seg(scan_seg), .scan_dp(scan_dp), .scan_an(scan_an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  initial begin
    bus.load = 0; bus.data_in = '0; bus.dp_in = '0; bus.mode = 0; bus.blank_lz = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    n = 0;

    // Reset state
    check("rst_segs", {4'h0, segs_static}, {4'h0, {4{7'b1000000}}});
    check("rst_shown", {16'h0, bus.shown_value}, 32'h0);
    check("rst_an", {28'h0, scan_an}, 32'hE);
    check("rst_ack", {31'h0, bus.load_ack}, 32'h0);
    check("rst_dp", {28'h0, dp_static}, 32'hF);

    // Static load of 12AF
    bus.load = 1; bus.data_in = 16'h12AF; bus.dp_in = 4'b0000;
    tick();
    bus.load = 0;
    check("st_shown_early", {16'h0, bus.shown_value}, 32'h0);
    check("st_ack_early", {31'h0, bus.load_ack}, 32'h0);
    tick();
    check("st_shown", {16'h0, bus.shown_value}, 32'h12AF);
    check("st_ack", {31'h0, bus.load_ack}, 32'h1);
    check("st_segs", {4'h0, segs_static},
          {4'h0, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});
    tick();
    check("st_ack_once", {31'h0, bus.load_ack}, 32'h0);

    // Scan timing: each anode held SCAN_DIV cycles, segments follow the nibble
    for (int i = 0; i < 20; i++) begin
      check("scan_an", {28'h0, scan_an}, {28'h0, ~(4'b0001 << ((n / SD) % ND))});
      check("scan_seg", {25'h0, scan_seg},
            {25'h0, enc(4'((16'h12AF >> (4 * ((n / SD) % ND))) & 16'hF))});
      tick();
    end

    // Scan tear-free: load mid-frame, commit only on frame-end edge
    bus.mode = 1;
    while (n % 16 != 5) tick();
    bus.load = 1; bus.data_in = 16'h00C3;
    tick();
    bus.load = 0;
    check("tf_hold", {16'h0, bus.shown_value}, 32'h12AF);
    while (n % 16 != 15) tick();
    check("tf_hold_last", {16'h0, bus.shown_value}, 32'h12AF);
    check("tf_ack_early", {31'h0, bus.load_ack}, 32'h0);
    tick();
    check("tf_shown", {16'h0, bus.shown_value}, 32'h00C3);
    check("tf_ack", {31'h0, bus.load_ack}, 32'h1);
    tick();
    check("tf_ack_once", {31'h0, bus.load_ack}, 32'h0);

    // Back-to-back loads before frame end: latest wins, single ack
    while (n % 16 != 2) tick();
    bus.load = 1; bus.data_in = 16'h1111;
    tick();
    bus.data_in = 16'h2222;
    tick();
    bus.load = 0;
    ackcnt = 0; bad = 0;
    while (n % 16 != 15) begin
      if (bus.load_ack) ackcnt++;
      tick();
    end
    check("b2b_hold", {16'h0, bus.shown_value}, 32'h00C3);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.load_ack) ackcnt++;
      if (bus.shown_value == 16'h1111) bad++;
    end
    check("b2b_shown", {16'h0, bus.shown_value}, 32'h2222);
    check("b2b_ackcnt", ackcnt, 1);
    check("b2b_no1111", bad, 0);

    // Load sampled on the frame-end edge waits a whole frame
    while (n % 16 != 15) tick();
    bus.load = 1; bus.data_in = 16'h0030; bus.dp_in = 4'b0000;
    tick();
    bus.load = 0;
    check("fe_hold", {16'h0, bus.shown_value}, 32'h2222);
    check("fe_ack0", {31'h0, bus.load_ack}, 32'h0);
    while (n % 16 != 15) tick();
    check("fe_hold_last", {16'h0, bus.shown_value}, 32'h2222);
    tick();
    check("fe_shown", {16'h0, bus.shown_value}, 32'h0030);
    check("fe_ack", {31'h0, bus.load_ack}, 32'h1);

    // Leading-zero blanking on 0030
    bus.blank_lz = 1;
    #1;
    check("blz_segs", {4'h0, segs_static}, {4'h0, BL, BL, 7'b0110000, 7'b1000000});
    while (n % 16 != 13) tick();
    check("blz_scan_an", {28'h0, scan_an}, 32'h7);
    check("blz_scan_seg", {25'h0, scan_seg}, {25'h0, BL});

    // Value 0 with dp on digit 3, committed by switching back to static mode
    while (n % 16 == 15) tick();
    bus.load = 1; bus.data_in = 16'h0000; bus.dp_in = 4'b1000;
    tick();
    bus.load = 0;
    bus.mode = 0;
    tick();
    check("sw_ack", {31'h0, bus.load_ack}, 32'h1);
    check("sw_shown", {16'h0, bus.shown_value}, 32'h0);
    check("blz0_segs", {4'h0, segs_static}, {4'h0, BL, BL, BL, 7'b1000000});
    check("blz0_dp", {28'h0, dp_static}, 32'h7);
    bus.blank_lz = 0;
    #1;
    check("noblz_segs", {4'h0, segs_static}, {4'h0, {4{7'b1000000}}});

    // Reset with a load pending in scan mode
    bus.load = 1; bus.data_in = 16'h5A5A; bus.dp_in = 4'b0000;
    tick();
    bus.load = 0;
    tick();
    tick();
    check("pre_rst_shown", {16'h0, bus.shown_value}, 32'h5A5A);
    bus.mode = 1;
    while (n % 16 != 3) tick();
    bus.load = 1; bus.data_in = 16'hBEEF; bus.dp_in = 4'b1111;
    tick();
    bus.load = 0;
    tick();
    reset = 1'b0;
    #2;
    check("mr_shown", {16'h0, bus.shown_value}, 32'h0);
    check("mr_an", {28'h0, scan_an}, 32'hE);
    check("mr_ack", {31'h0, bus.load_ack}, 32'h0);
    reset = 1'b1;
    n = 0;
    ackcnt = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.load_ack) ackcnt++;
      if (bus.shown_value != 16'h0) bad++;
    end
    check("mr_no_ack", ackcnt, 0);
    check("mr_stays0", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
